// File: rtl/conv3x3_set.sv
// rtl/conv3x3_set.sv - streaming 3x3 convolution, two line buffers, 4-stage MAC, ReLU/signed saturation
module conv3x3_set #(
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int MAX_W = 2048
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    input_axi_data,
  input  logic             input_axi_valid,
  input  logic             input_axi_last,
  output logic             input_axi_ready,
  output logic [DW-1:0]    output_axi_data,
  output logic             output_axi_valid,
  output logic             output_axi_last,
  input  logic             output_axi_ready,
  output logic             output_axi_keep,
  input  logic [11:0]      cfg_width,
  input  logic [11:0]      cfg_height,
  input  logic [4:0]       cfg_shift,
  input  logic             cfg_relu,
  input  logic [9*CW-1:0]  coe_flat,
  output logic             frame_err,
  output logic             busy
);
  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int PW = DW + CW + 1;
  localparam int SW = DW + CW + 5;
  localparam logic signed [SW-1:0] UMAX = $signed({{(SW-DW){1'b0}}, {DW{1'b1}}});
  localparam logic signed [SW-1:0] SMAX = $signed({{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}});
  localparam logic signed [SW-1:0] SMIN = $signed({{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}});

  logic            stall, accept, at_start, is_final, col_end, win_ok;
  logic [11:0]     col, row, w_l, h_l, w_eff, h_eff;
  logic [4:0]      sh_l;
  logic            relu_l;
  logic [9*CW-1:0] coe_l;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   rd0, rd1;
  logic [DW-1:0]   lb0 [MAX_W];
  logic [DW-1:0]   lb1 [MAX_W];
  logic [DW-1:0]   win [9];
  logic            wv, wl;

  assign stall           = output_axi_valid && !output_axi_ready;
  assign input_axi_ready = !stall;
  assign accept          = input_axi_valid && input_axi_ready;
  assign output_axi_keep = 1'b1;

  // On the first pixel of a frame the live config decides counter wrap, later the latched one
  assign at_start = (row == 12'd0) && (col == 12'd0);
  assign w_eff    = at_start ? cfg_width  : w_l;
  assign h_eff    = at_start ? cfg_height : h_l;
  assign col_end  = (col == w_eff - 12'd1);
  assign is_final = col_end && (row == h_eff - 12'd1);
  assign win_ok   = (row >= 12'd2) && (col >= 12'd2);
  assign addr     = col[AW-1:0];
  assign rd0      = lb0[addr];
  assign rd1      = lb1[addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      w_l       <= '0;
      h_l       <= '0;
      sh_l      <= '0;
      relu_l    <= 1'b0;
      coe_l     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= accept && (input_axi_last != is_final);
      if (accept) begin
        if (at_start) begin
          w_l    <= cfg_width;
          h_l    <= cfg_height;
          sh_l   <= cfg_shift;
          relu_l <= cfg_relu;
          coe_l  <= coe_flat;
        end
        if (is_final || input_axi_last) begin
          col <= '0;
          row <= '0;
        end else if (col_end) begin
          col <= '0;
          row <= row + 12'd1;
        end else begin
          col <= col + 12'd1;
        end
      end
    end
  end

  // lb0 holds row r-1, lb1 row r-2; read-before-write moves lb0 into lb1
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[addr] <= input_axi_data;
      lb1[addr] <= rd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
      wv <= 1'b0;
      wl <= 1'b0;
    end else if (!stall) begin
      wv <= accept && win_ok;
      wl <= accept && is_final && input_axi_last;
      if (accept) begin
        win[0] <= win[1]; win[1] <= win[2]; win[2] <= rd1;
        win[3] <= win[4]; win[4] <= win[5]; win[5] <= rd0;
        win[6] <= win[7]; win[7] <= win[8]; win[8] <= input_axi_data;
      end
    end
  end

  logic signed [PW-1:0] prod_c [9];
  logic signed [PW-1:0] p1 [9];
  logic signed [SW-1:0] ps_c [3];
  logic signed [SW-1:0] ps [3];
  logic signed [SW-1:0] acc, shd;
  logic [DW-1:0]        sat;
  logic                 v1, v2, v3, l1, l2, l3, r1, r2, r3;
  logic [4:0]           sh1, sh2, sh3;

  for (genvar i = 0; i < 9; i++) begin : g_mul
    assign prod_c[i] = $signed({{(CW+1){1'b0}}, win[i]}) *
                       $signed({{(DW+1){coe_l[i*CW+CW-1]}}, coe_l[i*CW +: CW]});
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    assign ps_c[r] = {{(SW-PW){p1[3*r][PW-1]}},   p1[3*r]}
                   + {{(SW-PW){p1[3*r+1][PW-1]}}, p1[3*r+1]}
                   + {{(SW-PW){p1[3*r+2][PW-1]}}, p1[3*r+2]};
  end

  assign shd = acc >>> sh3;

  always_comb begin
    sat = shd[DW-1:0];
    if (r3) begin
      if (shd[SW-1])       sat = '0;
      else if (shd > UMAX) sat = '1;
    end else begin
      if (shd > SMAX)      sat = {1'b0, {(DW-1){1'b1}}};
      else if (shd < SMIN) sat = {1'b1, {(DW-1){1'b0}}};
    end
  end

  // Shift/ReLU travel with each result so a back-to-back frame cannot retune in-flight data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) p1[i] <= '0;
      for (int i = 0; i < 3; i++) ps[i] <= '0;
      acc <= '0;
      {v1, v2, v3, l1, l2, l3, r1, r2, r3} <= '0;
      {sh1, sh2, sh3} <= '0;
      output_axi_valid <= 1'b0;
      output_axi_last  <= 1'b0;
      output_axi_data  <= '0;
    end else if (!stall) begin
      for (int i = 0; i < 9; i++) p1[i] <= prod_c[i];
      v1 <= wv; l1 <= wl; sh1 <= sh_l; r1 <= relu_l;
      for (int i = 0; i < 3; i++) ps[i] <= ps_c[i];
      v2 <= v1; l2 <= l1; sh2 <= sh1; r2 <= r1;
      acc <= ps[0] + ps[1] + ps[2];
      v3 <= v2; l3 <= l2; sh3 <= sh2; r3 <= r2;
      output_axi_valid <= v3;
      output_axi_last  <= v3 && l3;
      if (v3) output_axi_data <= sat;
    end
  end

  assign busy = !at_start || wv || v1 || v2 || v3 || output_axi_valid;
endmodule

// File: doc/conv3x3_set.md
CONV3X3_SET -- requirements
Module: conv3x3_set

Interface
REQ-001 Parameter DW, default 8, pixel data width (unsigned).
REQ-002 Parameter CW, default 8, coefficient width (signed two's complement).
REQ-003 Parameter MAX_W, default 2048, maximum line width; line buffer depth.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  reset; one clock, asynchronous, active-low.
REQ-006 input_axi_data  in  DW  raster-order input pixel.
REQ-007 input_axi_valid / input_axi_last  in  1 each  input valid; last pixel of frame.
REQ-008 input_axi_ready  out  1  input accepted when valid && ready.
REQ-009 output_axi_data  out  DW  result pixel.
REQ-010 output_axi_valid / output_axi_last  out  1 each  output valid; last output of frame.
REQ-011 output_axi_ready  in  1  downstream ready.
REQ-012 output_axi_keep  out  1  constant 1.
REQ-013 cfg_width / cfg_height  in  12 each  frame width W, height H; legal 3..MAX_W and 3..4095.
REQ-014 cfg_shift  in  5  arithmetic right-shift applied to the accumulator.
REQ-015 cfg_relu  in  1  1 = ReLU + unsigned saturation; 0 = signed saturation.
REQ-016 coe_flat  in  9*CW  coefficient k(r,c) at bits [(3r+c)*CW +: CW], r = row (0 oldest), c = column (0 oldest).
REQ-017 frame_err  out  1  one-cycle pulse on frame length error.
REQ-018 busy  out  1  high from first accepted pixel until last output of frame transferred.

Function
REQ-019 Accepted input transfer = input_axi_valid && input_axi_ready; output transfer = output_axi_valid && output_axi_ready.
REQ-020 cfg_* and coe_flat SHALL be latched on the first accepted pixel of each frame (busy low) and held for the whole frame; changes mid-frame have no effect.
REQ-021 Column counter (0..W-1) and row counter (0..H-1) SHALL advance per accepted pixel, column wrapping to 0 and incrementing row at W-1.
REQ-022 Two line buffers (depth MAX_W) SHALL hold rows r-1 and r-2 at column index; read-before-write at the same address in one cycle.
REQ-023 A 3x3 window register SHALL shift per accepted pixel; a window is valid iff row >= 2 and column >= 2 of the accepted pixel ("valid" convolution, no padding).
REQ-024 Per frame exactly (W-2)*(H-2) outputs, raster order; output_axi_last high only on the final one.
REQ-025 acc = sum over 9 taps of unsigned pixel (zero-extended) times signed coefficient, width DW+CW+5, no overflow.
REQ-026 Result = acc >>> cfg_shift (arithmetic, truncate toward negative infinity).
REQ-027 cfg_relu=1: result <0 -> 0, >2^DW-1 -> 2^DW-1; cfg_relu=0: saturate to [-2^(DW-1), 2^(DW-1)-1], output two's complement.
REQ-028 Pipeline: 4 stages (multiply, 3-tap partial sums, final sum, shift/saturate); output_axi_valid asserts 4 cycles after the completing pixel is accepted when not stalled.
REQ-029 Stall = output_axi_valid && !output_axi_ready; during stall all pipeline stages, window and counters SHALL freeze and output_axi_data/last SHALL hold stable.
REQ-030 input_axi_ready = !stall (combinational); full throughput of one pixel per cycle when output_axi_ready stays high.
REQ-031 Pixels with non-valid windows (row<2 or col<2) SHALL create pipeline bubbles, never output transfers.
REQ-032 input_axi_last asserted on pixel index != W*H-1 (early), or absent at index W*H-1 (late): frame_err pulses in the cycle after that pixel is accepted; counters return to row 0 col 0; in-flight outputs drain normally; next accepted pixel starts a new frame.
REQ-033 On an error-terminated frame output_axi_last SHALL NOT be asserted for that frame.
REQ-034 busy SHALL fall the cycle after the last-output transfer (or after drain following frame_err); back-to-back frames: a new frame's first pixel MAY be accepted while the previous frame drains, its config latched then.

Reset
REQ-035 While rst_n low: output_axi_valid=0, output_axi_last=0, output_axi_data=0, frame_err=0, busy=0, input_axi_ready=1; counters, window and pipeline valid bits cleared; line buffer contents need not be cleared.
REQ-036 Reset asserted mid-frame SHALL discard the frame; first pixel after release starts a new frame.

Verification
REQ-037 W=4,H=4, pixels 1..16, all coe=1, shift=0, relu=1 -> 4 outputs 54,63,90,99, last on 4th, first valid 4 cycles after pixel 11 accepted.
REQ-038 W=3,H=3, all pixels 255, all coe=127, shift=0 -> relu=1 gives 255; relu=0 gives 127; coe=-128, relu=1 gives 0; relu=0 gives -128 (0x80).
REQ-039 W=5,H=5 ramp, output_axi_ready random 50% -> output sequence identical to ready=1 run, data/last stable during every stall, exactly 9 outputs.
REQ-040 W=4,H=4, input_axi_last on pixel 10 -> frame_err pulse once, no output_axi_last, next 16-pixel frame produces correct 4 outputs.
REQ-041 coe_flat/cfg_shift changed mid-frame -> results use values latched at first pixel; next frame uses new values.
REQ-042 rst_n pulsed low during pixel 7 of W=4,H=4 frame -> all outputs 0 immediately, then a full fresh frame yields correct 4 outputs.
